// File: rtl/lift_scan_controller.sv
// Lift car controller using SCAN service order. It owns the floor position,
// the travel direction and the door sequence. It pulses one-cycle clears back
// to the hall-up, hall-down and car request queues.
module lift_scan_controller #(
    parameter int N_FLOORS      = 8,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32,
    parameter int CLOSE_CYCLES  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_FLOORS-1:0] i_up_req_queue,
    input  logic [N_FLOORS-1:0] i_dn_req_queue,
    input  logic [N_FLOORS-1:0] i_flr_req_queue,
    input  logic                i_door_obstruct,
    output logic [N_FLOORS-1:0] o_flr_pos,
    output logic                o_direction,
    output logic                o_motion,
    output logic                o_door_open,
    output logic [N_FLOORS-1:0] o_up_clr,
    output logic [N_FLOORS-1:0] o_dn_clr,
    output logic [N_FLOORS-1:0] o_flr_clr
);

    localparam int MAX_A = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int MAX_C = (MAX_A > CLOSE_CYCLES) ? MAX_A : CLOSE_CYCLES;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0]       T_LAST  = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0]       D_LAST  = CW'(DOOR_CYCLES - 1);
    localparam logic [CW-1:0]       C_LAST  = CW'(CLOSE_CYCLES - 1);
    localparam logic [CW-1:0]       CNT_ONE = CW'(1);
    localparam logic [N_FLOORS-1:0] POS_ONE = N_FLOORS'(1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR_OPEN, DOOR_CLOSE} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [N_FLOORS-1:0] pos, pos_n;
    logic                dir, dir_n;
    logic                svc;
    logic                motion, door_open;
    logic [N_FLOORS-1:0] up_clr, dn_clr, flr_clr;

    logic [N_FLOORS-1:0] req_all, arr_pos, dec_pos, above, below;
    logic                t_done, dec_en, clr_busy;
    logic                here_same, here_opp, ahead, behind;

    // The decision is made either at the current floor (IDLE, door states)
    // or at the floor the car is arriving at on a travel terminal count.
    assign req_all   = i_up_req_queue | i_dn_req_queue | i_flr_req_queue;
    assign t_done    = (state == MOVE) && (cnt == T_LAST);
    assign arr_pos   = dir ? (pos << 1) : (pos >> 1);
    assign dec_pos   = t_done ? arr_pos : pos;
    assign dec_en    = (state == IDLE) || t_done;
    assign below     = dec_pos - POS_ONE;
    assign above     = ~(dec_pos | below);
    assign here_same = |(dec_pos & (i_flr_req_queue | (dir ? i_up_req_queue : i_dn_req_queue)));
    assign here_opp  = |(dec_pos & (dir ? i_dn_req_queue : i_up_req_queue));
    assign ahead     = |(req_all & (dir ? above : below));
    assign behind    = |(req_all & (dir ? below : above));
    // A clear is in flight this cycle, so the queue bit seen now is stale.
    assign clr_busy  = |flr_clr;

    // Next-state: counters, position, direction and service request.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pos_n   = pos;
        dir_n   = dir;
        svc     = 1'b0;
        unique case (state)
            IDLE: ;
            MOVE: begin
                if (t_done) begin
                    pos_n   = arr_pos;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            DOOR_OPEN: begin
                if (here_same && !clr_busy) begin
                    svc   = 1'b1;
                    cnt_n = '0;
                end else if (i_door_obstruct) begin
                    cnt_n = '0;
                end else if (cnt == D_LAST) begin
                    state_n = DOOR_CLOSE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            DOOR_CLOSE: begin
                if (i_door_obstruct) begin
                    state_n = DOOR_OPEN;
                    cnt_n   = '0;
                end else if (cnt == C_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // SCAN priority: same-direction service, keep going, turn here, turn and go.
        if (dec_en) begin
            cnt_n = '0;
            if (here_same) begin
                state_n = DOOR_OPEN;
                svc     = 1'b1;
            end else if (ahead) begin
                state_n = MOVE;
            end else if (here_opp) begin
                dir_n   = ~dir;
                state_n = DOOR_OPEN;
                svc     = 1'b1;
            end else if (behind) begin
                dir_n   = ~dir;
                state_n = MOVE;
            end else begin
                state_n = IDLE;
            end
        end
    end

    // State, counter, position and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pos       <= POS_ONE;
            dir       <= 1'b1;
            motion    <= 1'b0;
            door_open <= 1'b0;
            up_clr    <= '0;
            dn_clr    <= '0;
            flr_clr   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pos       <= pos_n;
            dir       <= dir_n;
            motion    <= (state_n == MOVE);
            door_open <= (state_n == DOOR_OPEN) || (state_n == DOOR_CLOSE);
            flr_clr   <= svc ? pos_n : '0;
            up_clr    <= (svc && dir_n) ? pos_n : '0;
            dn_clr    <= (svc && !dir_n) ? pos_n : '0;
        end
    end

    assign o_flr_pos   = pos;
    assign o_direction = dir;
    assign o_motion    = motion;
    assign o_door_open = door_open;
    assign o_up_clr    = up_clr;
    assign o_dn_clr    = dn_clr;
    assign o_flr_clr   = flr_clr;

endmodule

// File: tb/tb_lift_scan_controller.sv
// Directed bench for lift_scan_controller (N=8, TRAVEL=4, DOOR=6, CLOSE=3).
// A small queue model holds requests until the matching clear pulse.
module tb_lift_scan_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] up_set, dn_set, flr_set;
    logic [7:0] up_q = '0, dn_q = '0, flr_q = '0;
    logic [7:0] i_up, i_dn, i_flr;
    logic       obstruct;
    logic [7:0] o_flr_pos, o_up_clr, o_dn_clr, o_flr_clr;
    logic       o_direction, o_motion, o_door_open;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    lift_scan_controller #(
        .N_FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6), .CLOSE_CYCLES(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_up_req_queue(i_up), .i_dn_req_queue(i_dn), .i_flr_req_queue(i_flr),
        .i_door_obstruct(obstruct),
        .o_flr_pos(o_flr_pos), .o_direction(o_direction), .o_motion(o_motion),
        .o_door_open(o_door_open),
        .o_up_clr(o_up_clr), .o_dn_clr(o_dn_clr), .o_flr_clr(o_flr_clr)
    );

    always #5 clk = ~clk;

    // Request queues: a set pulse is visible at once, held until cleared.
    assign i_up  = up_q | up_set;
    assign i_dn  = dn_q | dn_set;
    assign i_flr = flr_q | flr_set;

    // Queue bits drop on the clear pulse edge.
    always @(posedge clk) begin
        up_q  <= (up_q | up_set) & ~o_up_clr;
        dn_q  <= (dn_q | dn_set) & ~o_dn_clr;
        flr_q <= (flr_q | flr_set) & ~o_flr_clr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %02h expected %02h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0b expected %0b", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        up_set   = '0;
        dn_set   = '0;
        flr_set  = '0;
        obstruct = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk8("rst_pos", o_flr_pos, 8'h01);
        chk1("rst_dir", o_direction, 1'b1);
        chk1("rst_motion", o_motion, 1'b0);
        chk1("rst_door", o_door_open, 1'b0);
        chk8("rst_flr_clr", o_flr_clr, 8'h00);
        chk8("rst_up_clr", o_up_clr, 8'h00);
        chk8("rst_dn_clr", o_dn_clr, 8'h00);
        reset_n = 1'b1;
        cyc = 0;

        // Single car call to floor 3.
        flr_set = 8'h08;
        chk1("t1_idle", o_motion, 1'b0);
        tick();
        flr_set = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            wait_cyc(c);
            chk1("t1_motion", o_motion, 1'b1);
        end
        chk8("t1_pos_c12", o_flr_pos, 8'h04);
        wait_cyc(13);
        chk8("t1_pos", o_flr_pos, 8'h08);
        chk1("t1_motion_off", o_motion, 1'b0);
        chk1("t1_door", o_door_open, 1'b1);
        chk8("t1_flr_clr", o_flr_clr, 8'h08);
        chk8("t1_up_clr", o_up_clr, 8'h08);
        chk8("t1_dn_clr", o_dn_clr, 8'h00);
        wait_cyc(14);
        chk8("t1_flr_clr_once", o_flr_clr, 8'h00);
        wait_cyc(21);
        chk1("t1_door_last", o_door_open, 1'b1);
        wait_cyc(22);
        chk1("t1_door_shut", o_door_open, 1'b0);
        chk1("t1_idle_end", o_motion, 1'b0);

        // Obstruction in the second closing cycle restarts the full dwell.
        flr_set = 8'h08;
        wait_cyc(23);
        flr_set = 8'h00;
        chk8("t2_flr_clr", o_flr_clr, 8'h08);
        wait_cyc(30);
        obstruct = 1'b1;
        chk1("t2_closing", o_door_open, 1'b1);
        wait_cyc(31);
        obstruct = 1'b0;
        chk1("t2_reopen", o_door_open, 1'b1);
        chk8("t2_no_flr_clr", o_flr_clr, 8'h00);
        chk8("t2_no_up_clr", o_up_clr, 8'h00);
        wait_cyc(32);
        chk1("t2_still_open", o_door_open, 1'b1);
        wait_cyc(39);
        chk1("t2_door_last", o_door_open, 1'b1);
        wait_cyc(40);
        chk1("t2_door_shut", o_door_open, 1'b0);

        // Re-service: stale bit held through the pulse, then a fresh request mid-dwell.
        flr_set = 8'h08;
        wait_cyc(41);
        chk8("t3_flr_clr", o_flr_clr, 8'h08);
        wait_cyc(42);
        flr_set = 8'h00;
        chk8("t3_no_double", o_flr_clr, 8'h00);
        wait_cyc(43);
        flr_set = 8'h08;
        wait_cyc(44);
        flr_set = 8'h00;
        chk8("t3_reservice_flr", o_flr_clr, 8'h08);
        chk8("t3_reservice_up", o_up_clr, 8'h08);
        wait_cyc(45);
        chk8("t3_reservice_once", o_flr_clr, 8'h00);
        wait_cyc(52);
        chk1("t3_dwell_restart", o_door_open, 1'b1);
        wait_cyc(53);
        chk1("t3_door_shut", o_door_open, 1'b0);

        // Hall-up call below: travel down, turn at floor 2.
        up_set = 8'h04;
        wait_cyc(54);
        up_set = 8'h00;
        chk1("t4a_motion", o_motion, 1'b1);
        chk1("t4a_dir_down", o_direction, 1'b0);
        wait_cyc(58);
        chk8("t4a_pos", o_flr_pos, 8'h04);
        chk1("t4a_dir_up", o_direction, 1'b1);
        chk8("t4a_up_clr", o_up_clr, 8'h04);
        chk8("t4a_dn_clr", o_dn_clr, 8'h00);
        chk1("t4a_motion_off", o_motion, 1'b0);

        // SCAN order from floor 2 going up: 4, 5, then reverse to 0.
        wait_cyc(67);
        flr_set = 8'h21;
        up_set  = 8'h10;
        wait_cyc(68);
        flr_set = 8'h00;
        up_set  = 8'h00;
        chk1("t4b_motion", o_motion, 1'b1);
        chk1("t4b_dir", o_direction, 1'b1);
        wait_cyc(76);
        chk8("t4b_pos4", o_flr_pos, 8'h10);
        chk8("t4b_up_clr4", o_up_clr, 8'h10);
        chk8("t4b_flr_clr4", o_flr_clr, 8'h10);
        wait_cyc(85);
        chk1("t4b_idle4", o_door_open, 1'b0);
        wait_cyc(86);
        chk1("t4b_leave4", o_motion, 1'b1);
        wait_cyc(90);
        chk8("t4b_pos5", o_flr_pos, 8'h20);
        chk8("t4b_flr_clr5", o_flr_clr, 8'h20);
        chk1("t4b_dir5", o_direction, 1'b1);
        wait_cyc(99);
        chk1("t4b_dir5_idle", o_direction, 1'b1);
        wait_cyc(100);
        chk1("t4b_flip", o_direction, 1'b0);
        chk1("t4b_motion_down", o_motion, 1'b1);
        wait_cyc(120);
        chk8("t4b_pos0", o_flr_pos, 8'h01);
        chk8("t4b_flr_clr0", o_flr_clr, 8'h01);
        chk8("t4b_dn_clr0", o_dn_clr, 8'h01);
        chk8("t4b_up_clr0", o_up_clr, 8'h00);

        // Reset mid-travel between floors 4 and 5 with floors 5 and 7 pending.
        wait_cyc(129);
        flr_set = 8'hA0;
        wait_cyc(130);
        flr_set = 8'h00;
        chk1("t5_motion", o_motion, 1'b1);
        chk1("t5_dir", o_direction, 1'b1);
        wait_cyc(146);
        chk8("t5_pos4", o_flr_pos, 8'h10);
        wait_cyc(147);
        reset_n = 1'b0;
        #1;
        chk1("t5_rst_motion", o_motion, 1'b0);
        chk8("t5_rst_pos", o_flr_pos, 8'h01);
        chk1("t5_rst_dir", o_direction, 1'b1);
        tick();
        reset_n = 1'b1;
        chk1("t5_rel_idle", o_motion, 1'b0);
        wait_cyc(149);
        chk1("t5_restart", o_motion, 1'b1);
        wait_cyc(168);
        chk8("t5_pos4_again", o_flr_pos, 8'h10);
        chk1("t5_still_moving", o_motion, 1'b1);
        wait_cyc(169);
        chk8("t5_pos5", o_flr_pos, 8'h20);
        chk8("t5_flr_clr5", o_flr_clr, 8'h20);
        chk1("t5_motion_off", o_motion, 1'b0);
        wait_cyc(179);
        chk1("t5_leave5", o_motion, 1'b1);
        wait_cyc(187);
        chk8("t5_pos7", o_flr_pos, 8'h80);
        chk8("t5_up_clr7", o_up_clr, 8'h80);

        // Top floor with up and down calls while heading up, then reversal in place.
        wait_cyc(196);
        up_set = 8'h80;
        dn_set = 8'h80;
        wait_cyc(197);
        up_set = 8'h00;
        dn_set = 8'h00;
        chk8("t6_up_clr", o_up_clr, 8'h80);
        chk8("t6_dn_clr_none", o_dn_clr, 8'h00);
        chk1("t6_dir_up", o_direction, 1'b1);
        wait_cyc(207);
        chk8("t6_dn_clr", o_dn_clr, 8'h80);
        chk8("t6_flr_clr", o_flr_clr, 8'h80);
        chk8("t6_up_clr_none", o_up_clr, 8'h00);
        chk1("t6_dir_down", o_direction, 1'b0);
        chk1("t6_no_motion", o_motion, 1'b0);
        chk1("t6_door", o_door_open, 1'b1);
        wait_cyc(208);
        chk8("t6_dn_clr_once", o_dn_clr, 8'h00);

        wait_cyc(212);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lift_scan_controller.md
# lift_scan_controller

Parametrised lift car controller that owns the car's floor position, travel direction and door sequencing, and decides service order with a SCAN policy: keep going while requests lie ahead, then reverse. It sits between the per-floor request queues (hall up, hall down, car) and the motor and door drivers. It replaces combinational stop/go logic with a timed state machine: per-floor travel counter, door dwell and close counters, and obstruction reopen. It issues registered one-cycle, per-floor clear pulses back to the queues.

## Interface
- N_FLOORS, 8, number of floors (>= 2); bit i of every floor vector is floor i, floor 0 is the lowest
- TRAVEL_CYCLES, 16, clock cycles to travel one floor (>= 1)
- DOOR_CYCLES, 32, door-open dwell in cycles (>= 1)
- CLOSE_CYCLES, 8, door-closing duration in cycles (>= 1)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_up_req_queue  in  N_FLOORS  pending hall-up requests
- i_dn_req_queue  in  N_FLOORS  pending hall-down requests
- i_flr_req_queue  in  N_FLOORS  pending car (floor-select) requests
- i_door_obstruct  in  1  door obstruction sensor, level
- o_flr_pos  out  N_FLOORS  one-hot current floor
- o_direction  out  1  1 = up, 0 = down
- o_motion  out  1  car moving
- o_door_open  out  1  door not fully closed
- o_up_clr / o_dn_clr / o_flr_clr  out  N_FLOORS each  one-cycle per-floor clear pulses to the queues

## Operation
- States: IDLE, MOVE, DOOR_OPEN, DOOR_CLOSE.
- Outputs:
  - o_motion = (state == MOVE).
  - o_door_open = (state == DOOR_OPEN or DOOR_CLOSE).
- Terms, for position p and direction d:
  - here_same = flr[p] | (d ? up[p] : dn[p]).
  - here_opp = d ? dn[p] : up[p].
  - ahead = any request in any queue at a floor strictly beyond p in direction d.
  - behind = the same test in the opposite direction.
- Floor decision, in priority order:
  - (1) here_same: go to DOOR_OPEN and service at d.
  - (2) ahead: go to MOVE, keeping d.
  - (3) here_opp: flip d, go to DOOR_OPEN and service at the new d.
  - (4) behind: flip d, go to MOVE.
  - (5) otherwise stay IDLE and keep d.
- When the floor decision is evaluated:
  - IDLE: every cycle.
  - MOVE: at travel terminal count, evaluated against the arriving floor.
- Service action: in the first DOOR_OPEN cycle, pulse o_flr_clr[p] plus o_up_clr[p] if d = 1, else o_dn_clr[p]. Exactly one floor bit is set in any clear vector, and at most one pulse per queue per cycle.
- MOVE:
  - Travel counter runs 0..TRAVEL_CYCLES-1.
  - At terminal count, o_flr_pos shifts one place toward higher index (up) or lower index (down), and the counter reloads 0.
  - Because MOVE is entered only when ahead = 1, the position never shifts past floor 0 or floor N_FLOORS-1. No wrap-around.
- DOOR_OPEN:
  - Dwell counter runs 0..DOOR_CYCLES-1, then the state goes to DOOR_CLOSE.
  - i_door_obstruct reloads the dwell counter to 0.
  - If here_same = 1 in a cycle with no clear pulse asserted (a new request at this floor), re-pulse the service clears and reload the dwell counter.
- DOOR_CLOSE:
  - Counter runs 0..CLOSE_CYCLES-1, then the state goes to IDLE.
  - i_door_obstruct in any DOOR_CLOSE cycle returns the state to DOOR_OPEN with the dwell counter at 0 and no clear pulse.
- Counter widths: $clog2 of the largest of TRAVEL_CYCLES, DOOR_CYCLES and CLOSE_CYCLES, with a minimum of 1 bit. Counters never run past the terminal value.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, all counters = 0.
  - o_flr_pos = 1 (floor 0), o_direction = 1.
  - o_motion = 0, o_door_open = 0, all clear vectors = 0.
- Reset asserted mid-MOVE or with the door open: all of the above take effect immediately. Pending queue bits are untouched, and the controller re-decides from floor 0 after release.
- All outputs are registered; there is no combinational input-to-output path.
- IDLE to MOVE or DOOR_OPEN: 1 cycle after the request is present.
- Travel: k floors take exactly k*TRAVEL_CYCLES cycles with o_motion high. o_motion stays high between floors when continuing.
- Arrival to service: DOOR_OPEN and the clear pulse occur in the cycle after the terminal-count edge.
- Door cycle without obstruction: DOOR_CYCLES + CLOSE_CYCLES cycles, then IDLE.
- Queues clear on the pulse edge. The stale bit seen during the pulse cycle is ignored by the re-service rule.
- Simultaneous requests resolve by the decision priority above.
- A request at the current floor during MOVE is not serviced until the car reverses back to it.

## Test plan
- Single car call: N=8, TRAVEL=4, DOOR=6, CLOSE=3; after reset assert flr[3] at cycle 0 -> o_motion high cycles 1..12; o_flr_pos = 0x08 in cycle 13 with DOOR_OPEN; o_flr_clr = 0x08 for cycle 13 only; door open cycles 13..21; IDLE in cycle 22.
- SCAN order: car at floor 2 going up, requests flr[5], flr[0], up[4] -> stops at floor 4 (o_up_clr = 0x10), then 5, then reverses to 0; o_direction flips at floor 5.
- Reversal at a floor: car at floor 7 with only dn[7] pending -> o_direction goes 0 and o_dn_clr = 0x80 with no motion. Also cover dn[7] and up[7] at top with d = 1.
- Obstruction: assert i_door_obstruct in the 2nd DOOR_CLOSE cycle -> DOOR_OPEN next cycle, full DOOR_CYCLES dwell restarts, and no clear pulse.
- Re-service: assert flr[p] mid-dwell at the current floor -> one new o_flr_clr pulse and the dwell restarts. Holding flr[p] through the pulse cycle must not double-pulse.
- Reset mid-MOVE between floors 4 and 5 -> o_motion = 0 and o_flr_pos = 0x01 immediately. With flr[5] still pending, after release the car travels 5 floors up.
